// File: rtl/jtframe_i2s_rx.sv
// I2S receiver: oversamples BCLK/LRCLK/DATA with clk and deserialises MSB-first
// words into left/right, with a sample strobe per stereo pair and lock/slot status.
module jtframe_i2s_rx #(
   parameter int DW  = 16,
   parameter int TOW = 8
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          bclk,
   input  logic          lrclk,
   input  logic          sdata,
   output logic [DW-1:0] left,
   output logic [DW-1:0] right,
   output logic          sample,
   output logic          locked,
   output logic [5:0]    slot_bits
);

   typedef enum logic { UNLOCKED, LOCKED } state_t;

   state_t         state, state_nx;
   logic [2:0]     bclk_sh;
   logic [1:0]     lr_sh, sd_sh;
   logic           rise, lr, d, lr_edge, timeout;
   logic           lr_prev, resync;
   logic [5:0]     cnt;
   logic [DW-1:0]  sr, mask, word;
   logic [TOW-1:0] to_cnt;

   assign rise    = bclk_sh[1] & ~bclk_sh[2];
   assign lr      = lr_sh[1];
   assign d       = sd_sh[1];
   assign lr_edge = rise & ~resync & (lr != lr_prev);
   assign timeout = ~rise & (&to_cnt);
   assign locked  = (state == LOCKED);

   // Bits below the insertion point are always zero, so OR-ing in a one-hot mask
   // is enough; shifting past DW leaves the mask empty and drops extra slot bits.
   assign mask = {1'b1, {(DW-1){1'b0}}} >> cnt;
   assign word = sr | (d ? mask : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= UNLOCKED;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         UNLOCKED: if (lr_edge) state_nx = LOCKED;
         LOCKED:   if (timeout) state_nx = UNLOCKED;
         default:  state_nx = UNLOCKED;
      endcase
   end

   // resync starts set so that, after reset or lock loss, the first BCLK edge only
   // learns the current channel: a reset mid-slot never counts as an LR transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bclk_sh   <= '0;
         lr_sh     <= '0;
         sd_sh     <= '0;
         to_cnt    <= '0;
         cnt       <= '0;
         sr        <= '0;
         lr_prev   <= 1'b0;
         resync    <= 1'b1;
         left      <= '0;
         right     <= '0;
         sample    <= 1'b0;
         slot_bits <= '0;
      end else begin
         bclk_sh <= {bclk_sh[1:0], bclk};
         lr_sh   <= {lr_sh[0], lrclk};
         sd_sh   <= {sd_sh[0], sdata};
         sample  <= 1'b0;

         if (rise)         to_cnt <= '0;
         else if (!(&to_cnt)) to_cnt <= to_cnt + TOW'(1);

         if (state == LOCKED && timeout) begin
            cnt    <= '0;
            sr     <= '0;
            resync <= 1'b1;
         end else if (rise) begin
            if (resync) begin
               lr_prev <= lr;
               resync  <= 1'b0;
            end else if (lr == lr_prev) begin
               sr <= word;
               if (cnt != 6'd63) cnt <= cnt + 6'd1;
            end else begin
               // d is the LSB of the channel that just ended (one-bit I2S delay)
               slot_bits <= (cnt == 6'd63) ? 6'd63 : cnt + 6'd1;
               sr        <= '0;
               cnt       <= '0;
               lr_prev   <= lr;
               if (state == LOCKED) begin
                  if (!lr_prev) left <= word;
                  else begin
                     right  <= word;
                     sample <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule
